// File: rtl/issue_checker.sv
// issue_checker: watches the issue stage of an out-of-order core for illegal
// issues (sources not ready, FU busy, duplicate tags in one cycle) and, when
// built with ISSUE_CHK_STALL_EN defined, for stalls where ready work sits in
// the reservation stations but nothing issues. The first violation after arm
// is captured, per-class counters/sticky flags accumulate, and halt is raised.
// Optional feature macro: ISSUE_CHK_STALL_EN (stall watchdog).
module issue_checker #(
  parameter int NUM_CH    = 4,
  parameter int TAG_W     = 6,
  parameter int CNT_W     = 8,
  parameter int STALL_WIN = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        clear,
  input  logic [NUM_CH-1:0]           issue_valid,
  input  logic [NUM_CH-1:0]           src1_ready,
  input  logic [NUM_CH-1:0]           src2_ready,
  input  logic [NUM_CH-1:0]           fu_free,
  input  logic [NUM_CH*TAG_W-1:0]     issue_tag,
  input  logic                        rs_ready_any,
  output logic [3:0]                  err_sticky,
  output logic [4*CNT_W-1:0]          err_count,
  output logic [1:0]                  first_class,
  output logic [$clog2(NUM_CH)-1:0]   first_ch,
  output logic [31:0]                 first_cycle,
  output logic                        halt,
  output logic [1:0]                  state
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [NUM_CH-1:0] src_vec;
  logic [NUM_CH-1:0] struct_vec;
  logic [NUM_CH-1:0] dup_vec;
  logic              stall_hit;
  logic [3:0]        class_hit;
  logic [1:0]        cap_class;
  logic [CH_W-1:0]   cap_ch;
  logic              capture;
  logic [31:0]       cycle_q;
  logic [CNT_W-1:0]  cnt_q [4];

  // Index of the lowest set bit; used to pick the winning channel in a class.
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest = CH_W'(i);
    end
  endfunction

  // Per-channel violation vectors; a duplicate tag is blamed on the higher channel.
  always_comb begin
    src_vec    = '0;
    struct_vec = '0;
    dup_vec    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      src_vec[i]    = issue_valid[i] & ~(src1_ready[i] & src2_ready[i]);
      struct_vec[i] = issue_valid[i] & ~fu_free[i];
      for (int j = 0; j < i; j++) begin
        if (issue_valid[i] && issue_valid[j] &&
            (issue_tag[i*TAG_W +: TAG_W] == issue_tag[j*TAG_W +: TAG_W]))
          dup_vec[i] = 1'b1;
      end
    end
  end

`ifdef ISSUE_CHK_STALL_EN
  localparam int SW_W = $clog2(STALL_WIN + 1);
  logic [SW_W-1:0] stall_q;
  logic            stall_cond;

  assign stall_cond = rs_ready_any && (issue_valid == '0);
  assign stall_hit  = stall_cond && (stall_q == SW_W'(STALL_WIN - 1));

  // Watchdog: counts consecutive ready-but-idle cycles, restarting after a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_q <= '0;
    else if (!stall_cond || stall_hit)
      stall_q <= '0;
    else
      stall_q <= stall_q + SW_W'(1);
  end
`else
  logic unused_rs_ready;
  assign unused_rs_ready = rs_ready_any;
  assign stall_hit       = 1'b0;
`endif

  // Violations only matter once the checker has been armed.
  assign class_hit = (state_q != IDLE) ?
                     {stall_hit, |dup_vec, |struct_vec, |src_vec} : 4'b0000;

  // Capture selection: SRC beats STRUCT beats DUP beats STALL.
  always_comb begin
    cap_class = 2'd3;
    cap_ch    = '0;
    if (class_hit[0]) begin
      cap_class = 2'd0;
      cap_ch    = lowest(src_vec);
    end else if (class_hit[1]) begin
      cap_class = 2'd1;
      cap_ch    = lowest(struct_vec);
    end else if (class_hit[2]) begin
      cap_class = 2'd2;
      cap_ch    = lowest(dup_vec);
    end
  end

  assign capture = (state_q == ARMED) && !clear && (|class_hit);

  // Next-state logic; clear wins over any violation in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (!clear && (|class_hit)) state_d = TRIPPED;
      TRIPPED: if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered halt so halt follows the violation by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      halt    <= 1'b0;
    end else begin
      state_q <= state_d;
      halt    <= (state_d == TRIPPED);
    end
  end

  assign state = state_q;

  // Free-running cycle stamp used to timestamp the first violation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cycle_q <= '0;
    else
      cycle_q <= cycle_q + 32'd1;
  end

  // Sticky flags and saturating per-class counters, one step per cycle per class.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sticky <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else if (clear) begin
      err_sticky <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (class_hit[k]) begin
          err_sticky[k] <= 1'b1;
          if (cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Flatten the counters into the output bus, SRC in the lowest slice.
  always_comb begin
    err_count = '0;
    for (int k = 0; k < 4; k++) err_count[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  // First-violation capture, loaded only when the checker trips.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_class <= '0;
      first_ch    <= '0;
      first_cycle <= '0;
    end else if (clear) begin
      first_class <= '0;
      first_ch    <= '0;
      first_cycle <= '0;
    end else if (capture) begin
      first_class <= cap_class;
      first_ch    <= cap_ch;
      first_cycle <= cycle_q;
    end
  end

endmodule

// File: tb/tb_issue_checker.sv
// tb_issue_checker: directed scenarios plus randomized traffic for
// issue_checker, compared each cycle against a rule-level reference model.
module tb_issue_checker;
  localparam int NUM_CH    = 4;
  localparam int TAG_W     = 6;
  localparam int CNT_W     = 2;
  localparam int STALL_WIN = 64;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic                     arm = 1'b0;
  logic                     clear = 1'b0;
  logic                     rs_ready_any = 1'b0;
  logic [NUM_CH-1:0]        issue_valid = '0;
  logic [NUM_CH-1:0]        src1_ready = '0;
  logic [NUM_CH-1:0]        src2_ready = '0;
  logic [NUM_CH-1:0]        fu_free = '0;
  logic [NUM_CH*TAG_W-1:0]  issue_tag = '0;
  logic [3:0]               err_sticky;
  logic [4*CNT_W-1:0]       err_count;
  logic [1:0]               first_class;
  logic [1:0]               first_ch;
  logic [31:0]              first_cycle;
  logic                     halt;
  logic [1:0]               state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 idle, 1 armed, 2 tripped
  int          m_state;
  bit [3:0]    m_sticky;
  int          m_cnt [4];
  int          m_first_class;
  int          m_first_ch;
  int unsigned m_first_cycle;
  int unsigned m_cycle;
  int          m_stall_run;

  issue_checker #(
    .NUM_CH(NUM_CH), .TAG_W(TAG_W), .CNT_W(CNT_W), .STALL_WIN(STALL_WIN)
  ) dut (
    .clock(clock), .reset(reset), .arm(arm), .clear(clear),
    .issue_valid(issue_valid), .src1_ready(src1_ready), .src2_ready(src2_ready),
    .fu_free(fu_free), .issue_tag(issue_tag), .rs_ready_any(rs_ready_any),
    .err_sticky(err_sticky), .err_count(err_count), .first_class(first_class),
    .first_ch(first_ch), .first_cycle(first_cycle), .halt(halt), .state(state)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_sticky = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_first_class = 0;
    m_first_ch = 0;
    m_first_cycle = 0;
    m_cycle = 0;
    m_stall_run = 0;
  endtask

  // One clock of the rules: classify violations, then apply the state/record updates.
  task automatic modelStep();
    bit hit [4];
    int ch [4];
    bit any;
    for (int k = 0; k < 4; k++) begin
      hit[k] = 1'b0;
      ch[k] = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (issue_valid[i]) begin
        if (!src1_ready[i] || !src2_ready[i]) begin
          if (!hit[0]) ch[0] = i;
          hit[0] = 1'b1;
        end
        if (!fu_free[i]) begin
          if (!hit[1]) ch[1] = i;
          hit[1] = 1'b1;
        end
        for (int j = 0; j < i; j++) begin
          if (issue_valid[j] && issue_tag[i*TAG_W +: TAG_W] == issue_tag[j*TAG_W +: TAG_W]) begin
            if (!hit[2]) ch[2] = i;
            hit[2] = 1'b1;
          end
        end
      end
    end
`ifdef ISSUE_CHK_STALL_EN
    if (rs_ready_any && issue_valid == '0) begin
      m_stall_run++;
      if (m_stall_run == STALL_WIN) begin
        hit[3] = 1'b1;
        m_stall_run = 0;
      end
    end else begin
      m_stall_run = 0;
    end
`endif
    if (m_state == 0)
      for (int k = 0; k < 4; k++) hit[k] = 1'b0;
    any = hit[0] | hit[1] | hit[2] | hit[3];
    if (clear) begin
      m_sticky = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      m_first_class = 0;
      m_first_ch = 0;
      m_first_cycle = 0;
      if (m_state == 2) m_state = 0;
      else if (m_state == 0 && arm) m_state = 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hit[k]) begin
          m_sticky[k] = 1'b1;
          if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
        end
      end
      if (m_state == 1 && any) begin
        for (int k = 3; k >= 0; k--) begin
          if (hit[k]) begin
            m_first_class = k;
            m_first_ch = ch[k];
          end
        end
        m_first_cycle = m_cycle;
        m_state = 2;
      end else if (m_state == 0 && arm) begin
        m_state = 1;
      end
    end
    m_cycle++;
  endtask

  task automatic compareAll();
    logic [4*CNT_W-1:0] exp_cnt;
    for (int k = 0; k < 4; k++) exp_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("halt", 32'(halt), 32'(m_state == 2));
    checkOutput("err_sticky", 32'(err_sticky), 32'(m_sticky));
    checkOutput("err_count", 32'(err_count), 32'(exp_cnt));
    checkOutput("first_class", 32'(first_class), 32'(m_first_class));
    checkOutput("first_ch", 32'(first_ch), 32'(m_first_ch));
    checkOutput("first_cycle", first_cycle, m_first_cycle);
  endtask

  // Drive one cycle of inputs, step the model on the edge, check just after it.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] fr,
                               input logic [23:0] tags, input logic rs,
                               input logic a, input logic c);
    issue_valid = v;
    src1_ready = s1;
    src2_ready = s2;
    fu_free = fr;
    issue_tag = tags;
    rs_ready_any = rs;
    arm = a;
    clear = c;
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic quiet(input logic a, input logic c);
    applyStimulus(4'h0, 4'hF, 4'hF, 4'hF, 24'h0, 1'b0, a, c);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    compareAll();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_cycle", first_cycle, 32'd0);

    // Illegal source: channel 0 issues with src1 not ready
    quiet(1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'hF, 4'hF, 24'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("src_halt", 32'(halt), 32'd1);
    checkOutput("src_class", 32'(first_class), 32'd0);
    checkOutput("src_ch", 32'(first_ch), 32'd0);
    checkOutput("src_count", 32'(err_count[CNT_W-1:0]), 32'd1);
    quiet(1'b0, 1'b1);

    // Duplicate tag 5 on channels 1 and 3
    quiet(1'b1, 1'b0);
    applyStimulus(4'b1010, 4'hF, 4'hF, 4'hF, {6'd5, 6'd0, 6'd5, 6'd0}, 1'b0, 1'b0, 1'b0);
    checkOutput("dup_class", 32'(first_class), 32'd2);
    checkOutput("dup_ch", 32'(first_ch), 32'd3);
    quiet(1'b0, 1'b1);

    // Channel 2 FU busy and channel 1 src2 not ready together
    quiet(1'b1, 1'b0);
    applyStimulus(4'b0110, 4'hF, 4'b1101, 4'b1011, {6'd0, 6'd2, 6'd1, 6'd0}, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_class", 32'(first_class), 32'd0);
    checkOutput("sim_ch", 32'(first_ch), 32'd1);
    checkOutput("sim_sticky", 32'(err_sticky[1:0]), 32'd3);
    quiet(1'b0, 1'b1);

    // Saturation after five SRC violations, then clear beating a violation
    quiet(1'b1, 1'b0);
    repeat (5) applyStimulus(4'b0001, 4'b0000, 4'hF, 4'hF, 24'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_count", 32'(err_count[CNT_W-1:0]), 32'd3);
    applyStimulus(4'b0001, 4'b0000, 4'hF, 4'hF, 24'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_count", 32'(err_count), 32'd0);
    checkOutput("clr_sticky", 32'(err_sticky), 32'd0);
    checkOutput("clr_state", 32'(state), 32'd0);

    // Stall watchdog
    quiet(1'b1, 1'b0);
`ifdef ISSUE_CHK_STALL_EN
    repeat (STALL_WIN - 1) applyStimulus(4'h0, 4'hF, 4'hF, 4'hF, 24'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_63_state", 32'(state), 32'd1);
    applyStimulus(4'h0, 4'hF, 4'hF, 4'hF, 24'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_64_state", 32'(state), 32'd2);
    checkOutput("stall_class", 32'(first_class), 32'd3);
    checkOutput("stall_ch", 32'(first_ch), 32'd0);
    quiet(1'b0, 1'b1);
    quiet(1'b1, 1'b0);
`else
    repeat (STALL_WIN + 6) applyStimulus(4'h0, 4'hF, 4'hF, 4'hF, 24'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("nostall_state", 32'(state), 32'd1);
    checkOutput("nostall_sticky", 32'(err_sticky[3]), 32'd0);
`endif

    // Clear while armed drops the violation and keeps the checker armed
    applyStimulus(4'b0001, 4'b0000, 4'hF, 4'hF, 24'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("armclr_state", 32'(state), 32'd1);
    checkOutput("armclr_count", 32'(err_count), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] v, s1, s2, fr;
      logic [23:0] tg;
      for (int i = 0; i < NUM_CH; i++) begin
        v[i]  = ($urandom_range(0, 99) < 45);
        s1[i] = ($urandom_range(0, 99) < 90);
        s2[i] = ($urandom_range(0, 99) < 90);
        fr[i] = ($urandom_range(0, 99) < 90);
        tg[i*TAG_W +: TAG_W] = 6'($urandom_range(0, 7));
      end
      applyStimulus(v, s1, s2, fr, tg, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 6));
    end

    // Reset pulse while tripped takes effect before the next edge
    quiet(1'b0, 1'b1);
    quiet(1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 4'hF, 4'hF, 24'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_state", 32'(state), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_halt", 32'(halt), 32'd0);
    checkOutput("async_rst_state", 32'(state), 32'd0);
    checkOutput("async_rst_sticky", 32'(err_sticky), 32'd0);
    checkOutput("async_rst_cycle", first_cycle, 32'd0);
    modelReset();
    issue_valid = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    compareAll();
    quiet(1'b1, 1'b0);
    applyStimulus(4'b0100, 4'hF, 4'hF, 4'b1011, 24'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_class", 32'(first_class), 32'd1);
    checkOutput("post_rst_cycle", first_cycle, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
